// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Frame: 0xA5, length, data bytes, 8-bit wrapping checksum.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        SUM,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // A length byte of zero stands for a full 256-byte image
    function automatic logic [8:0] frame_len(input logic [7:0] l);
        return (l == 8'd0) ? 9'd256 : {1'b0, l};
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Byte stream from the serial receiver to the loader FSM.
// The receiver is the master; the loader consumes as slave.
interface uart_program_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    modport master (
        output byte_valid,
        output byte_data,
        output frame_err
    );

    modport slave (
        input byte_valid,
        input byte_data,
        input frame_err
    );

endinterface

// File: rtl/uart_program_loader_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, half-bit start check,
// mid-bit sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    uart_program_loader_if.master rxb
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1;
    logic          sync2;
    logic          prev;
    rx_state_t     state;
    rx_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    nbit;
    logic [2:0]    nbit_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic [7:0]    data;
    logic [7:0]    data_n;
    logic          valid;
    logic          valid_n;
    logic          ferr;
    logic          ferr_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            state <= RX_IDLE;
            cnt   <= '0;
            nbit  <= '0;
            shift <= '0;
            data  <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
            state <= state_n;
            cnt   <= cnt_n;
            nbit  <= nbit_n;
            shift <= shift_n;
            data  <= data_n;
            valid <= valid_n;
            ferr  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        nbit_n  = nbit;
        shift_n = shift;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (prev && !sync2)
                    state_n = RX_START;
            end
            RX_START: begin
                // A start that is gone by mid-bit was a glitch
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    nbit_n  = '0;
                    state_n = sync2 ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shift_n = {sync2, shift[7:1]};
                    nbit_n  = nbit + 1'b1;
                    if (nbit == 3'd7)
                        state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (sync2) begin
                        valid_n = 1'b1;
                        data_n  = shift;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign rxb.byte_valid = valid;
    assign rxb.byte_data  = data;
    assign rxb.frame_err  = ferr;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives an image on rx, writes imem, holds the CPU.
// Optional ACK/NAK on tx: define UART_PROGRAM_LOADER_ACK_EN.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       cpu_hold,
    output logic       imem_w_en,
    output logic [7:0] imem_addr,
    output logic [7:0] imem_w_data,
    output logic       done,
    output logic       error,
    output logic       tx
);

    uart_program_loader_if rxb ();

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock(clock),
        .reset(reset),
        .rx   (rx),
        .rxb  (rxb)
    );

    state_t     state;
    state_t     state_n;
    logic [8:0] n_bytes;
    logic [8:0] idx;
    logic [7:0] sum;
    logic       load_len;
    logic       take;

    always_comb begin
        state_n  = state;
        load_len = 1'b0;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxb.byte_valid && rxb.byte_data == HDR_BYTE)
                    state_n = LEN;
            end
            LEN: begin
                if (rxb.frame_err) begin
                    state_n = ERR;
                end else if (rxb.byte_valid) begin
                    load_len = 1'b1;
                    state_n  = DATA;
                end
            end
            DATA: begin
                if (rxb.frame_err) begin
                    state_n = ERR;
                end else if (rxb.byte_valid) begin
                    take = 1'b1;
                    if (idx + 9'd1 == n_bytes)
                        state_n = SUM;
                end
            end
            SUM: begin
                if (rxb.frame_err)
                    state_n = ERR;
                else if (rxb.byte_valid)
                    state_n = (rxb.byte_data == sum) ? DONE : ERR;
            end
            DONE: state_n = DONE;
            ERR: begin
                if (rxb.byte_valid && rxb.byte_data == HDR_BYTE)
                    state_n = LEN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n_bytes     <= '0;
            idx         <= '0;
            sum         <= '0;
            imem_w_en   <= 1'b0;
            imem_addr   <= '0;
            imem_w_data <= '0;
        end else begin
            state     <= state_n;
            imem_w_en <= take;
            if (load_len) begin
                n_bytes <= frame_len(rxb.byte_data);
                idx     <= '0;
                sum     <= '0;
            end
            if (take) begin
                imem_addr   <= idx[7:0];
                imem_w_data <= rxb.byte_data;
                sum         <= sum + rxb.byte_data;
                idx         <= idx + 9'd1;
            end
        end
    end

    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

`ifdef UART_PROGRAM_LOADER_ACK_EN
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_t        prev_state;
    logic          tx_busy;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_left;
    logic [CW-1:0] tx_cnt;
    logic          entered;

    assign entered = (state != prev_state) &&
                     (state == DONE || state == ERR);

    // A running NAK finishes before any new reply starts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_state <= IDLE;
            tx_busy    <= 1'b0;
            tx_shift   <= '1;
            tx_left    <= '0;
            tx_cnt     <= '0;
        end else begin
            prev_state <= state;
            if (!tx_busy && entered) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1,
                             (state == DONE) ? ACK_BYTE : NAK_BYTE,
                             1'b0};
                tx_left  <= 4'd10;
                tx_cnt   <= '0;
            end else if (tx_busy) begin
                if (tx_cnt == LAST) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_left  <= tx_left - 4'd1;
                    if (tx_left == 4'd1)
                        tx_busy <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    assign tx = tx_busy ? tx_shift[0] : 1'b1;
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frame table plus
// hand-written corner sequences (framing, glitch, reset, 256 bytes).
module tb_uart_program_loader;

    localparam int CPB = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       cpu_hold;
    logic       imem_w_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_w_data;
    logic       done;
    logic       error;
    logic       tx;

    always #5 clock = ~clock;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .cpu_hold   (cpu_hold),
        .imem_w_en  (imem_w_en),
        .imem_addr  (imem_addr),
        .imem_w_data(imem_w_data),
        .done       (done),
        .error      (error),
        .tx         (tx)
    );

    uart_program_loader_if mon ();
    assign mon.byte_valid = dut.rxb.byte_valid;
    assign mon.byte_data  = dut.rxb.byte_data;
    assign mon.frame_err  = dut.rxb.frame_err;

    int checks = 0;
    int errors = 0;
    int nw = 0;
    int wide = 0;
    int nbv = 0;
    int nfe = 0;
    logic prev_wen = 1'b0;
    logic [7:0] wa [512];
    logic [7:0] wd [512];

    always @(negedge clock) begin
        if (imem_w_en) begin
            if (nw < 512) begin
                wa[nw] = imem_addr;
                wd[nw] = imem_w_data;
            end
            nw++;
            if (prev_wen)
                wide++;
        end
        prev_wen = imem_w_en;
        if (mon.byte_valid)
            nbv++;
        if (mon.frame_err)
            nfe++;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic capture_tx(output logic [7:0] b, output logic ok);
        int t;
        b  = '0;
        ok = 1'b0;
        t  = 0;
        while (tx !== 1'b0 && t < 40 * CPB) begin
            @(negedge clock);
            t++;
        end
        if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clock);
            ok = (tx === 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        nw = 0;
        wide = 0;
        @(negedge clock);
    endtask

    typedef struct {
        logic            noise;
        logic [7:0]      len;
        logic [2:0][7:0] d;
        logic [7:0]      chk;
        logic            exp_done;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] txb;
        logic       txok;
        int         bad;
        int         b0;
        int         f0;

        vecs[0] = '{1'b0, 8'd3, {8'h33, 8'h22, 8'h11}, 8'h66, 1'b1};
        vecs[1] = '{1'b0, 8'd3, {8'h33, 8'h22, 8'h11}, 8'h67, 1'b0};
        vecs[2] = '{1'b1, 8'd1, {8'h00, 8'h00, 8'h7E}, 8'h7E, 1'b1};
        vecs[3] = '{1'b0, 8'd2, {8'h00, 8'h02, 8'hFF}, 8'h01, 1'b1};
        vecs[4] = '{1'b1, 8'd2, {8'h00, 8'h20, 8'h10}, 8'h00, 1'b0};

        #1 reset = 1'b1;
        @(negedge clock);
        check("rst cpu_hold", cpu_hold, 1);
        check("rst w_en", imem_w_en, 0);
        check("rst addr", imem_addr, 0);
        check("rst wdata", imem_w_data, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst tx", tx, 1);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            if (vecs[v].noise) begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
            end
            send_byte(8'hA5, 1'b1);
            send_byte(vecs[v].len, 1'b1);
            for (int k = 0; k < int'(vecs[v].len); k++)
                send_byte(vecs[v].d[k], 1'b1);
`ifdef UART_PROGRAM_LOADER_ACK_EN
            fork
                send_byte(vecs[v].chk, 1'b1);
                capture_tx(txb, txok);
            join
            check($sformatf("v%0d tx framed", v), txok, 1);
            check($sformatf("v%0d tx byte", v), txb,
                  vecs[v].exp_done ? 8'h06 : 8'h15);
`else
            send_byte(vecs[v].chk, 1'b1);
`endif
            repeat (2 * CPB) @(negedge clock);
            check($sformatf("v%0d done", v), done, vecs[v].exp_done);
            check($sformatf("v%0d error", v), error, !vecs[v].exp_done);
            check($sformatf("v%0d hold", v), cpu_hold, !vecs[v].exp_done);
            check($sformatf("v%0d nwrites", v), nw, vecs[v].len);
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                check($sformatf("v%0d addr%0d", v, k), wa[k], k);
                check($sformatf("v%0d data%0d", v, k), wd[k], vecs[v].d[k]);
            end
`ifndef UART_PROGRAM_LOADER_ACK_EN
            check($sformatf("v%0d tx idle", v), tx, 1);
`endif
        end

        // Bad checksum, then a good frame clears error
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h67, 1'b1);
        repeat (4) @(negedge clock);
        check("retry error set", error, 1);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clock);
        check("retry error cleared", error, 0);
        check("retry hold", cpu_hold, 1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'h78, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        check("retry done", done, 1);
        check("retry nwrites", nw, 5);
        check("retry addr", wa[4], 8'h01);
        check("retry data", wd[3], 8'hAB);

        // Framing error on the second data byte
        do_reset();
        f0 = nfe;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (2 * CPB) @(negedge clock);
        check("ferr error", error, 1);
        check("ferr nwrites", nw, 1);
        check("ferr pulses", nfe - f0, 1);

        // Short low glitch while idle
        do_reset();
        b0 = nbv;
        f0 = nfe;
        @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("glitch bytes", nbv - b0, 0);
        check("glitch ferr", nfe - f0, 0);
        check("glitch error", error, 0);
        check("glitch done", done, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        check("glitch then load", done, 1);

        // Reset in the middle of DATA
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (2) @(negedge clock);
        check("mid wdata before", imem_w_data, 8'h11);
        rx = 1'b0;
        repeat (20) @(negedge clock);
        #3 reset = 1'b1;
        #1;
        check("mid hold", cpu_hold, 1);
        check("mid wdata", imem_w_data, 0);
        check("mid addr", imem_addr, 0);
        check("mid w_en", imem_w_en, 0);
        check("mid done", done, 0);
        check("mid error", error, 0);
        check("mid tx", tx, 1);
        rx = 1'b1;
        repeat (CPB) @(negedge clock);
        reset = 1'b0;
        nw = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'h78, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        check("post-reset done", done, 1);
        check("post-reset addr0", wa[0], 0);
        check("post-reset data1", wd[1], 8'hCD);

        // L=0: 256 bytes of value i, checksum 0x80
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++)
            send_byte(8'(i), 1'b1);
        send_byte(8'h80, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        check("full done", done, 1);
        check("full nwrites", nw, 256);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wa[i] !== 8'(i) || wd[i] !== 8'(i))
                bad++;
        check("full contents", bad, 0);
        check("strobe width", wide, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
